// File: rtl/stoch_div_pkg.sv
// Shared types and helpers for the stochastic divider scheduler.
package stoch_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WARM  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Feedback tap mask of a maximal-length shift-left Fibonacci LFSR of width w.
  // Widths 3..10 are tabulated; other widths fall back to the 6-bit mask.
  function automatic logic [31:0] lfsrTaps(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      default: return 32'h0000_0030;
    endcase
  endfunction

  // Mid-scale starting point of the divider core counter.
  function automatic logic [31:0] midPoint(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/stoch_div_sched_core.sv
// Counter-based stochastic divider core: a saturating up/down counter whose
// value, compared against a random number, produces the quotient stream.
module sdiv_core
  import stoch_div_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_rand,
  input  logic         i_dividend,
  input  logic         i_divisor,
  output logic         o_quotient
);

  localparam logic [W-1:0] MID = W'(midPoint(W));
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic         w_inc;
  logic         w_dec;

  assign o_quotient = (r_cnt >= i_rand);
  assign w_inc      = i_dividend;
  assign w_dec      = o_quotient & i_divisor;

  // Saturating counter: dividend ones push up, quotient-and-divisor ones pull down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= MID;
    end else if (i_clr) begin
      r_cnt <= MID;
    end else if (i_en) begin
      if (w_inc && !w_dec && (r_cnt != MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/stoch_div_sched.sv
// Round-robin scheduler sharing one stochastic divider core between requesters.
module stoch_div_sched
  import stoch_div_pkg::*;
#(
  parameter int           N_REQ  = 4,
  parameter int           W      = 6,
  parameter int           LEN_W  = 10,
  parameter int           WARMUP = 16,
  parameter logic [W-1:0] SEED_A = W'('h2B),
  parameter logic [W-1:0] SEED_B = W'('h15),
  parameter logic [W-1:0] SEED_C = W'('h39)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_dividend,
  input  logic [N_REQ*W-1:0]         req_divisor,
  input  logic [LEN_W-1:0]           req_len,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [LEN_W-1:0]           rsp_count,
  output logic                       busy
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int WUW  = $clog2(WARMUP + 1);
  localparam int CW   = (WUW > LEN_W) ? WUW : LEN_W;
  localparam logic [W-1:0] TAPS = W'(lfsrTaps(W));

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [W-1:0]     r_dvd;
  logic [W-1:0]     r_dvs;
  logic [LEN_W-1:0] r_len;
  logic [CW-1:0]    r_cyc;
  logic [LEN_W-1:0] r_count;
  logic             r_rspValid;
  logic             r_busy;
  logic [W-1:0]     r_lfsrA;
  logic [W-1:0]     r_lfsrB;
  logic [W-1:0]     r_lfsrC;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   w_idx;
  logic             w_found;
  logic             w_accept;
  logic             w_streamEn;
  logic             w_bitA;
  logic             w_bitB;
  logic             w_quot;

  // Round-robin pick: first pending requester at or after the pointer.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gidx         = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  assign req_ready  = (r_state == IDLE) ? w_grant : '0;
  assign w_accept   = |req_ready;
  assign w_streamEn = (r_state == WARM) || (r_state == RUN);
  assign w_bitA     = (r_lfsrA < r_dvd);
  assign w_bitB     = (r_lfsrB < r_dvs);

  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_id;
  assign rsp_count = r_count;
  assign busy      = r_busy;

  // Random sources only advance while the core is running so each job is repeatable from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsrA <= SEED_A;
      r_lfsrB <= SEED_B;
      r_lfsrC <= SEED_C;
    end else if (w_streamEn) begin
      r_lfsrA <= {r_lfsrA[W-2:0], ^(r_lfsrA & TAPS)};
      r_lfsrB <= {r_lfsrB[W-2:0], ^(r_lfsrB & TAPS)};
      r_lfsrC <= {r_lfsrC[W-2:0], ^(r_lfsrC & TAPS)};
    end
  end

  sdiv_core #(
    .W (W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == CLEAR),
    .i_en       (w_streamEn),
    .i_rand     (r_lfsrC),
    .i_dividend (w_bitA),
    .i_divisor  (w_bitB),
    .o_quotient (w_quot)
  );

  // Job sequencing: latch the winner, clear, warm up, count, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_len      <= '0;
      r_cyc      <= '0;
      r_count    <= '0;
      r_rspValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id    <= w_gidx;
            r_dvd   <= req_dividend[w_gidx*W +: W];
            r_dvs   <= req_divisor[w_gidx*W +: W];
            r_len   <= req_len;
            r_busy  <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_count <= '0;
          r_cyc   <= CW'(WARMUP - 1);
          r_state <= WARM;
        end
        WARM: begin
          if (r_cyc == '0) begin
            if (r_len == '0) begin
              r_rspValid <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_cyc   <= CW'(r_len) - 1'b1;
              r_state <= RUN;
            end
          end else begin
            r_cyc <= r_cyc - 1'b1;
          end
        end
        RUN: begin
          if (w_quot && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
          end
          if (r_cyc == '0) begin
            r_rspValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cyc <= r_cyc - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_busy     <= 1'b0;
            r_ptr      <= (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_div_sched.sv
// Randomized self-checking bench for stoch_div_sched with a job-level reference model.
module tb_stoch_div_sched;

  localparam int N      = 4;
  localparam int W      = 6;
  localparam int LEN_W  = 10;
  localparam int WARMUP = 16;
  localparam int BW     = N * W;
  localparam int SEED_A = 'h2B;
  localparam int SEED_B = 'h15;
  localparam int SEED_C = 'h39;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [BW-1:0]    req_dividend = '0;
  logic [BW-1:0]    req_divisor = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [LEN_W-1:0] rsp_count;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int mA, mB, mC, mPtr;
  int opDvd[N];
  int opDvs[N];

  stoch_div_sched #(
    .N_REQ (N), .W (W), .LEN_W (LEN_W), .WARMUP (WARMUP),
    .SEED_A (6'h2B), .SEED_B (6'h15), .SEED_C (6'h39)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_len      (req_len),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_count    (rsp_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One step of the 6-bit maximal-length sequence x^6 + x^5 + 1.
  function automatic int lfsrStep(input int s);
    return ((s << 1) & 63) | (((s >> 5) ^ (s >> 4)) & 1);
  endfunction

  // Whole-job reference: warm-up plus counted window of the stochastic divider.
  function automatic int modelJob(input int dvd, input int dvs, input int len);
    int cnt, count, q, inc, dec;
    cnt = 32;
    count = 0;
    for (int c = 0; c < WARMUP + len; c++) begin
      inc = (mA < dvd) ? 1 : 0;
      q   = (cnt >= mC) ? 1 : 0;
      dec = (q == 1 && mB < dvs) ? 1 : 0;
      if (c >= WARMUP && count < 1023) count = count + q;
      if (inc == 1 && dec == 0 && cnt < 63) cnt = cnt + 1;
      else if (dec == 1 && inc == 0 && cnt > 0) cnt = cnt - 1;
      mA = lfsrStep(mA);
      mB = lfsrStep(mB);
      mC = lfsrStep(mC);
    end
    return count;
  endfunction

  function automatic int modelArb(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return 0;
  endfunction

  task automatic driveOps();
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = W'(opDvd[i]);
      req_divisor[i*W +: W]  = W'(opDvs[i]);
    end
  endtask

  task automatic doReset();
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mA = SEED_A; mB = SEED_B; mC = SEED_C; mPtr = 0;
  endtask

  // Offer a job, follow it to its response, optionally stall the response, then take it.
  task automatic applyStimulus(input logic [N-1:0] mask, input int len, input int stall,
                               input bit keepValid, output int gotId, output int gotCount,
                               output int waited);
    int  n, expId, expCount;
    bit  leak, stallBad, busyOk;
    @(negedge clk);
    req_valid = mask;
    req_len   = LEN_W'(len);
    driveOps();
    #1;
    n = 0;
    while (req_ready == '0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    waited = n;
    expId = modelArb(mask);
    checkOutput("grant", int'(req_ready), 1 << expId);
    expCount = modelJob(opDvd[expId], opDvs[expId], len);
    n = 0; leak = 0; busyOk = 0;
    do begin
      @(negedge clk); #1; n++;
      if (n == 1) begin
        busyOk = busy;
        if (!keepValid) req_valid = '0;
        req_dividend = BW'($urandom);
        req_divisor  = BW'($urandom);
        req_len      = LEN_W'($urandom);
      end
      if (req_ready != '0) leak = 1;
    end while (!rsp_valid && n < 3000);
    checkOutput("busy", int'(busyOk), 1);
    checkOutput("latency", n, 2 + WARMUP + len);
    checkOutput("rsp_id", int'(rsp_id), expId);
    checkOutput("rsp_count", int'(rsp_count), expCount);
    checkOutput("ready_leak", int'(leak), 0);
    gotId = int'(rsp_id);
    gotCount = int'(rsp_count);
    stallBad = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      if (!rsp_valid || int'(rsp_id) != gotId || int'(rsp_count) != gotCount || req_ready != '0)
        stallBad = 1;
    end
    if (stall > 0) checkOutput("stall_hold", int'(stallBad), 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    mPtr = (expId + 1) % N;
    checkOutput("rsp_drop", int'(rsp_valid), 0);
  endtask

  initial begin
    int id, cnt, waited, count1, sawRsp;
    int order[4];
    logic [N-1:0] mask;
    mA = SEED_A; mB = SEED_B; mC = SEED_C; mPtr = 0;
    #1;
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_rsp_count", int'(rsp_count), 0);
    checkOutput("reset_rsp_id", int'(rsp_id), 0);
    checkOutput("reset_req_ready", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single job from requester 0 straight after power-on
    opDvd[0] = 16; opDvs[0] = 32;
    applyStimulus(4'b0001, 256, 0, 1'b0, id, cnt, waited);
    checkOutput("t1_id", id, 0);
    checkOutput("t1_range", int'(cnt >= 112 && cnt <= 144), 1);
    count1 = cnt;

    // Saturating quotient cases
    opDvd[0] = 32; opDvs[0] = 0;
    applyStimulus(4'b0001, 256, 0, 1'b0, id, cnt, waited);
    checkOutput("t2_high", int'(cnt >= 240), 1);
    opDvd[0] = 0; opDvs[0] = 63;
    applyStimulus(4'b0001, 256, 0, 1'b0, id, cnt, waited);
    checkOutput("t2_low", int'(cnt <= 24), 1);

    // Round-robin order with held requests
    doReset();
    for (int i = 0; i < N; i++) begin
      opDvd[i] = 10 + 12 * i; opDvs[i] = 50 - 8 * i;
    end
    applyStimulus(4'b0101, 32, 0, 1'b1, id, cnt, waited);
    checkOutput("t3_first", id, 0);
    applyStimulus(4'b0101, 32, 0, 1'b1, id, cnt, waited);
    checkOutput("t3_second", id, 2);
    order = '{3, 0, 1, 2};
    for (int j = 0; j < 4; j++) begin
      applyStimulus(4'b1111, 24, 0, 1'b1, id, cnt, waited);
      checkOutput("t3_rr", id, order[j]);
    end

    // Response back-pressure, then back-to-back accept
    applyStimulus(4'b0010, 20, 5, 1'b1, id, cnt, waited);
    checkOutput("t4_id", id, 1);
    applyStimulus(4'b0010, 20, 0, 1'b0, id, cnt, waited);
    checkOutput("t4_next_wait", waited, 0);

    // Zero-length job skips the counting window
    applyStimulus(4'b0001, 0, 0, 1'b0, id, cnt, waited);
    checkOutput("t6_count", cnt, 0);

    // Randomized jobs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        opDvd[i] = $urandom_range(0, 63);
        opDvs[i] = $urandom_range(0, 63);
      end
      mask = N'($urandom_range(1, 15));
      applyStimulus(mask, $urandom_range(0, 60), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), id, cnt, waited);
    end

    // Reset in the middle of a counting window
    doReset();
    opDvd[0] = 16; opDvs[0] = 32;
    driveOps();
    req_len = LEN_W'(256);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checkOutput("t5_grant", int'(req_ready), 1);
    @(negedge clk);
    req_valid = '0;
    repeat (2 + WARMUP + 40) @(negedge clk);
    checkOutput("t5_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_rsp_valid", int'(rsp_valid), 0);
    checkOutput("t5_rsp_count", int'(rsp_count), 0);
    checkOutput("t5_rsp_id", int'(rsp_id), 0);
    checkOutput("t5_req_ready", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    mA = SEED_A; mB = SEED_B; mC = SEED_C; mPtr = 0;
    sawRsp = 0;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid || busy) sawRsp = 1;
    end
    checkOutput("t5_no_rsp", sawRsp, 0);
    applyStimulus(4'b0001, 256, 0, 1'b0, id, cnt, waited);
    checkOutput("t5_repeat", cnt, count1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
